mips_instr_encoder: RTL and testbench

- Reverse of the main control decoder: takes an instruction class plus its operand fields and packs them into a 32-bit MIPS instruction word.
- Writes each word into instruction memory at an auto-incrementing address, through a valid/ready input handshake and an ack-based memory write port.
- Used as the program loader / self-test generator feeding the single-cycle datapath.
- Covers exactly the opcode set the control unit decodes: R-type, lw, sw, beq, j, addi, lui, jal, ori.

---
 rtl/mips_instr_encoder.sv | 170 +++++++++++++++++
 tb/tb_mips_instr_encoder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : mips_instr_encoder
//  Purpose  : Packs an instruction class plus its operand fields into a 32-bit
//             MIPS instruction word and writes it to instruction memory at an
//             auto-incrementing address. Acts as program loader / self-test
//             generator for the single-cycle datapath.
//  Ports    : clk, reset (sync, active-high), clear (sync restart)
//             in_valid/in_ready          - field bundle handshake
//             op_sel, rs, rt, rd, shamt, funct, imm, target - operand fields
//             mem_we/mem_addr/mem_wdata/mem_ack - memory write port
//             word_count, full, err      - status
//  Revision : 1.0  initial release
// ============================================================================
module mips_instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_STEP = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W-1:0] C_BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] C_STEP  = ADDR_W'(ADDR_STEP);
  localparam logic [ADDR_W:0]   C_DEPTH = (ADDR_W+1)'(DEPTH);

  localparam logic [5:0] C_OP_R    = 6'b000000;
  localparam logic [5:0] C_OP_LW   = 6'b100011;
  localparam logic [5:0] C_OP_SW   = 6'b101011;
  localparam logic [5:0] C_OP_BEQ  = 6'b000100;
  localparam logic [5:0] C_OP_J    = 6'b000010;
  localparam logic [5:0] C_OP_ADDI = 6'b001000;
  localparam logic [5:0] C_OP_LUI  = 6'b001111;
  localparam logic [5:0] C_OP_JAL  = 6'b000011;
  localparam logic [5:0] C_OP_ORI  = 6'b001101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic [31:0]       r_wdata;
  logic              r_err;

  logic [31:0]       w_word;
  logic              w_op_ok;
  logic              w_accept;
  logic              w_acked;
  logic [ADDR_W:0]   w_count_inc;

  // --------------------------------------------------------------------------
  // Field packer: pure combinational map from class + fields to a word.
  // --------------------------------------------------------------------------
  always_comb begin
    w_word  = 32'h0;
    w_op_ok = 1'b1;
    case (op_sel)
      4'd0:    w_word = {C_OP_R, rs, rt, rd, shamt, funct};
      4'd1:    w_word = {C_OP_LW, rs, rt, imm};
      4'd2:    w_word = {C_OP_SW, rs, rt, imm};
      4'd3:    w_word = {C_OP_BEQ, rs, rt, imm};
      4'd4:    w_word = {C_OP_J, target};
      4'd5:    w_word = {C_OP_ADDI, rs, rt, imm};
      4'd6:    w_word = {C_OP_LUI, 5'b00000, rt, imm};  // rs forced to zero
      4'd7:    w_word = {C_OP_JAL, target};
      4'd8:    w_word = {C_OP_ORI, rs, rt, imm};
      default: w_op_ok = 1'b0;
    endcase
  end

  assign w_accept    = (r_state == S_IDLE) && in_valid;
  // An ack only counts while a write is actually outstanding.
  assign w_acked     = (r_state == S_WRITE) && mem_ack;
  assign w_count_inc = r_count + (ADDR_W+1)'(1);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_op_ok) begin
          w_next_state = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          w_next_state = (w_count_inc == C_DEPTH) ? S_FULL : S_IDLE;
        end
      end
      S_FULL:  w_next_state = S_FULL;
      default: w_next_state = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers. clear keeps the last word; only reset zeroes it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= C_BASE;
      r_count <= '0;
      r_wdata <= 32'h0;
      r_err   <= 1'b0;
    end else if (clear) begin
      r_addr  <= C_BASE;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_op_ok) begin
          r_wdata <= w_word;
        end else begin
          r_err <= 1'b1;
        end
      end
      if (w_acked) begin
        r_addr  <= r_addr + C_STEP;
        r_count <= w_count_inc;
      end
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign mem_we     = (r_state == S_WRITE);
  assign full       = (r_state == S_FULL);
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign word_count = r_count;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_instr_encoder
//  Purpose  : Directed self-checking bench for mips_instr_encoder. Instance
//             u_dut_a uses DEPTH=256, u_dut_b uses DEPTH=4; both share all
//             inputs so the small instance can be driven into FULL.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mips_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, clear, in_valid, mem_ack;
  logic [3:0]  op_sel;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;

  logic        a_in_ready, a_mem_we, a_full, a_err;
  logic [7:0]  a_mem_addr;
  logic [31:0] a_mem_wdata;
  logic [8:0]  a_word_count;

  logic        b_in_ready, b_mem_we, b_full, b_err;
  logic [7:0]  b_mem_addr;
  logic [31:0] b_mem_wdata;
  logic [8:0]  b_word_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_addr;
  int exp_count;

  always #5 clk = ~clk;

  mips_instr_encoder #(.ADDR_W(8), .DEPTH(256), .BASE_ADDR(0), .ADDR_STEP(4)) u_dut_a (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .target(target),
    .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_ack(mem_ack),
    .word_count(a_word_count), .full(a_full), .err(a_err)
  );

  mips_instr_encoder #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(0), .ADDR_STEP(4)) u_dut_b (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .target(target),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_ack(mem_ack),
    .word_count(b_word_count), .full(b_full), .err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [3:0] op, input logic [4:0] rs_v, input logic [4:0] rt_v,
                            input logic [4:0] rd_v, input logic [4:0] sh_v, input logic [5:0] fn_v,
                            input logic [15:0] im_v, input logic [25:0] tg_v);
    op_sel = op; rs = rs_v; rt = rt_v; rd = rd_v;
    shamt = sh_v; funct = fn_v; imm = im_v; target = tg_v;
  endtask

  // Handshake with ack already high (ignored in IDLE), then one WRITE cycle.
  task automatic do_write(input string tag, input logic [31:0] exp_word);
    chk({tag, ".ready"}, {31'b0, a_in_ready}, 32'd1);
    in_valid = 1'b1;
    mem_ack  = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, ".we"},    {31'b0, a_mem_we}, 32'd1);
    chk({tag, ".word"},  a_mem_wdata, exp_word);
    chk({tag, ".addr"},  {24'b0, a_mem_addr}, exp_addr);
    chk({tag, ".cnt0"},  {23'b0, a_word_count}, exp_count);
    tick();
    mem_ack = 1'b0;
    exp_addr  += 4;
    exp_count += 1;
    chk({tag, ".we_off"}, {31'b0, a_mem_we}, 32'd0);
    chk({tag, ".cnt1"},   {23'b0, a_word_count}, exp_count);
    chk({tag, ".addr1"},  {24'b0, a_mem_addr}, exp_addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
    set_fields(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    tick(); tick();
    reset = 1'b0;
    exp_addr = 0; exp_count = 0;

    // Reset state
    chk("rst.ready", {31'b0, a_in_ready}, 32'd1);
    chk("rst.we",    {31'b0, a_mem_we}, 32'd0);
    chk("rst.addr",  {24'b0, a_mem_addr}, 32'd0);
    chk("rst.wdata", a_mem_wdata, 32'd0);
    chk("rst.cnt",   {23'b0, a_word_count}, 32'd0);
    chk("rst.full",  {31'b0, a_full}, 32'd0);
    chk("rst.err",   {31'b0, a_err}, 32'd0);

    // R-type add $8,$9,$10
    set_fields(4'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'hFFFF, 26'h3FFFFFF);
    do_write("radd", 32'h012A4020);

    // Field sequence, addresses 4..20
    set_fields(4'd1, 5'd29, 5'd8, 5'd31, 5'd31, 6'h3F, 16'h0004, 26'h3FFFFFF);
    do_write("lw", 32'h8FA80004);
    set_fields(4'd6, 5'd7, 5'd1, 5'd0, 5'd0, 6'h00, 16'h1001, 26'd0);
    do_write("lui", 32'h3C011001);
    set_fields(4'd3, 5'd8, 5'd0, 5'd0, 5'd0, 6'h00, 16'hFFFE, 26'd0);
    do_write("beq", 32'h1100FFFE);
    set_fields(4'd7, 5'd31, 5'd31, 5'd0, 5'd0, 6'h00, 16'hFFFF, 26'h0100000);
    do_write("jal", 32'h0C100000);
    set_fields(4'd8, 5'd0, 5'd2, 5'd0, 5'd0, 6'h00, 16'h00FF, 26'd0);
    do_write("ori", 32'h340200FF);

    // Remaining classes, addresses 24..32
    set_fields(4'd2, 5'd29, 5'd31, 5'd0, 5'd0, 6'h00, 16'h0008, 26'd0);
    do_write("sw", 32'hAFBF0008);
    set_fields(4'd4, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF);
    do_write("j", 32'h0BFFFFFF);
    set_fields(4'd5, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h8000, 26'd0);
    do_write("addi", 32'h20088000);

    // Backpressure: ack held low for three WRITE cycles
    set_fields(4'd0, 5'd1, 5'd2, 5'd3, 5'd4, 6'h05, 16'd0, 26'd0);
    in_valid = 1'b1; mem_ack = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp.we",    {31'b0, a_mem_we}, 32'd1);
      chk("bp.addr",  {24'b0, a_mem_addr}, exp_addr);
      chk("bp.word",  a_mem_wdata, 32'h00221905);
      chk("bp.ready", {31'b0, a_in_ready}, 32'd0);
      tick();
    end
    chk("bp.we4", {31'b0, a_mem_we}, 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    exp_addr += 4; exp_count += 1;
    chk("bp.addr_adv", {24'b0, a_mem_addr}, exp_addr);
    chk("bp.cnt",      {23'b0, a_word_count}, exp_count);

    // Invalid op_sel
    set_fields(4'hF, 5'd1, 5'd1, 5'd1, 5'd1, 6'h01, 16'h1, 26'h1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("inv.err",   {31'b0, a_err}, 32'd1);
    chk("inv.we",    {31'b0, a_mem_we}, 32'd0);
    chk("inv.cnt",   {23'b0, a_word_count}, exp_count);
    chk("inv.ready", {31'b0, a_in_ready}, 32'd1);
    set_fields(4'd5, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0010, 26'd0);
    do_write("after_inv", 32'h20220010);
    chk("inv.err_sticky", {31'b0, a_err}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_addr = 0; exp_count = 0;
    chk("clr.err",  {31'b0, a_err}, 32'd0);
    chk("clr.addr", {24'b0, a_mem_addr}, 32'd0);
    chk("clr.cnt",  {23'b0, a_word_count}, 32'd0);

    // Clear during WRITE with ack in the same cycle
    set_fields(4'd1, 5'd3, 5'd4, 5'd0, 5'd0, 6'h00, 16'h0040, 26'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("cw.we", {31'b0, a_mem_we}, 32'd1);
    clear = 1'b1; mem_ack = 1'b1;
    tick();
    clear = 1'b0; mem_ack = 1'b0;
    chk("cw.we_off", {31'b0, a_mem_we}, 32'd0);
    chk("cw.cnt",    {23'b0, a_word_count}, 32'd0);
    chk("cw.addr",   {24'b0, a_mem_addr}, 32'd0);
    chk("cw.ready",  {31'b0, a_in_ready}, 32'd1);
    chk("cw.wdata_kept", a_mem_wdata, 32'h8C640040);

    // Full on the DEPTH=4 instance (both instances start from clear)
    set_fields(4'd8, 5'd0, 5'd9, 5'd0, 5'd0, 6'h00, 16'h0001, 26'd0);
    do_write("f0", 32'h34090001);
    do_write("f1", 32'h34090001);
    do_write("f2", 32'h34090001);
    chk("f.b_notfull", {31'b0, b_full}, 32'd0);
    do_write("f3", 32'h34090001);
    chk("f.b_full",  {31'b0, b_full}, 32'd1);
    chk("f.b_ready", {31'b0, b_in_ready}, 32'd0);
    chk("f.b_cnt",   {23'b0, b_word_count}, 32'd4);
    chk("f.b_addr",  {24'b0, b_mem_addr}, 32'd16);
    chk("f.a_full",  {31'b0, a_full}, 32'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("f.b_no_we", {31'b0, b_mem_we}, 32'd0);
    chk("f.a_we",    {31'b0, a_mem_we}, 32'd1);
    chk("f.b_still", {31'b0, b_full}, 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("f.b_cnt_hold", {23'b0, b_word_count}, 32'd4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("f.clr_addr",  {24'b0, b_mem_addr}, 32'd0);
    chk("f.clr_cnt",   {23'b0, b_word_count}, 32'd0);
    chk("f.clr_ready", {31'b0, b_in_ready}, 32'd1);
    chk("f.clr_full",  {31'b0, b_full}, 32'd0);

    // Reset during WRITE
    set_fields(4'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'd0, 26'h0000123);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rw.word", a_mem_wdata, 32'h08000123);
    reset = 1'b1; mem_ack = 1'b1;
    tick();
    reset = 1'b0; mem_ack = 1'b0;
    chk("rw.ready", {31'b0, a_in_ready}, 32'd1);
    chk("rw.we",    {31'b0, a_mem_we}, 32'd0);
    chk("rw.addr",  {24'b0, a_mem_addr}, 32'd0);
    chk("rw.wdata", a_mem_wdata, 32'd0);
    chk("rw.cnt",   {23'b0, a_word_count}, 32'd0);
    chk("rw.full",  {31'b0, a_full}, 32'd0);
    chk("rw.err",   {31'b0, a_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
